// File: rtl/simd_sign_fixup.sv
// Signed-result fixup after an unsigned SIMD engine; tag FIFO records {sew, neg} at issue, one-cycle registered output.
// Stalls results while no tag is queued or the output is held; optional SIMD_SIGN_FIXUP_OVF_EN adds out_ovf_o.
module simd_sign_fixup #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int RATIO     = MAX_WIDTH / MIN_WIDTH,
  parameter int SEW_WIDTH = $clog2(RATIO) + 1,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iss_valid_i,
  output logic                         iss_ready_o,
  input  logic [SEW_WIDTH-1:0]         iss_sew_i,
  input  logic [RATIO-1:0]             iss_neg_i,
  input  logic                         res_valid_i,
  output logic                         res_ready_o,
  input  logic [MAX_WIDTH-1:0]         res_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [MAX_WIDTH-1:0]         out_data_o,
  output logic [SEW_WIDTH-1:0]         out_sew_o,
  output logic [$clog2(TAG_DEPTH):0]   tag_count_o
`ifdef SIMD_SIGN_FIXUP_OVF_EN
  ,
  output logic [RATIO-1:0]             out_ovf_o
`endif
);

  localparam int CW   = $clog2(RATIO);
  localparam int PW   = $clog2(TAG_DEPTH);
  localparam int CNTW = PW + 1;

  typedef struct packed {
    logic [SEW_WIDTH-1:0] sew;
    logic [RATIO-1:0]     neg;
  } tag_t;

  tag_t                 tag_mem_q [TAG_DEPTH];
  tag_t                 head;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 empty, full, push, pop;

  logic                 out_valid_q;
  logic [MAX_WIDTH-1:0] out_data_q;
  logic [SEW_WIDTH-1:0] out_sew_q;

  logic [CW-1:0]        elem_mask;
  logic [RATIO-1:0]     inv;
  logic                 carry, cin;
  logic [MIN_WIDTH-1:0] sum;
  logic [MAX_WIDTH-1:0] fixed;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNTW'(TAG_DEPTH));
  assign head  = tag_mem_q[rd_ptr_q];

  assign res_ready_o = !rst && !empty && (!out_valid_q || out_ready_i);
  assign pop         = res_valid_i && res_ready_o;
  assign iss_ready_o = !rst && (!full || pop);
  assign push        = iss_valid_i && iss_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= {iss_sew_i, iss_neg_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  // elem_mask has ones over the chunk-index bits that stay inside one element,
  // so k|mask is the element's top chunk and k&mask==0 marks its lowest chunk.
  always_comb begin
    elem_mask = '0;
    for (int i = 0; i < SEW_WIDTH; i++) begin
      if (head.sew[i]) elem_mask = elem_mask | CW'((RATIO >> i) - 1);
    end
    inv   = '0;
    fixed = '0;
    carry = 1'b0;
    cin   = 1'b0;
    sum   = '0;
    for (int k = 0; k < RATIO; k++) begin
      inv[k] = head.neg[CW'(k) | elem_mask];
      cin    = ((CW'(k) & elem_mask) == '0) ? inv[k] : carry;
      {carry, sum} = {1'b0, res_data_i[k*MIN_WIDTH +: MIN_WIDTH] ^ {MIN_WIDTH{inv[k]}}}
                   + {{MIN_WIDTH{1'b0}}, cin};
      fixed[k*MIN_WIDTH +: MIN_WIDTH] = sum;
    end
  end

`ifdef SIMD_SIGN_FIXUP_OVF_EN
  logic [RATIO-1:0] ovf, out_ovf_q;
  logic             low_nz;

  // Magnitude top bit set overflows unless negating exactly 2^(w-1).
  always_comb begin
    ovf    = '0;
    low_nz = 1'b0;
    for (int k = 0; k < RATIO; k++) begin
      if ((CW'(k) | elem_mask) == CW'(k)) begin
        low_nz = |res_data_i[k*MIN_WIDTH +: MIN_WIDTH-1];
        for (int j = 0; j < RATIO; j++) begin
          if (j != k && (CW'(j) | elem_mask) == CW'(k))
            low_nz = low_nz | (|res_data_i[j*MIN_WIDTH +: MIN_WIDTH]);
        end
        ovf[k] = res_data_i[k*MIN_WIDTH + MIN_WIDTH-1] & (~head.neg[k] | low_nz);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      out_ovf_q <= '0;
    else if (pop) out_ovf_q <= ovf;
  end

  assign out_ovf_o = out_ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sew_q   <= '0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= fixed;
      out_sew_q   <= head.sew;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sew_o   = out_sew_q;
  assign tag_count_o = cnt_q;

endmodule

// File: tb/tb_simd_sign_fixup.sv
// Directed bench for simd_sign_fixup with hand-computed expected results.
module tb_simd_sign_fixup;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid_i, iss_ready_o;
  logic [3:0]  iss_sew_i;
  logic [7:0]  iss_neg_i;
  logic        res_valid_i, res_ready_o;
  logic [63:0] res_data_i;
  logic        out_valid_o, out_ready_i;
  logic [63:0] out_data_o;
  logic [3:0]  out_sew_o;
  logic [2:0]  tag_count_o;
`ifdef SIMD_SIGN_FIXUP_OVF_EN
  logic [7:0]  out_ovf_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  simd_sign_fixup dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (iss_valid_i),
    .iss_ready_o (iss_ready_o),
    .iss_sew_i   (iss_sew_i),
    .iss_neg_i   (iss_neg_i),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .res_data_i  (res_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_sew_o   (out_sew_o),
    .tag_count_o (tag_count_o)
`ifdef SIMD_SIGN_FIXUP_OVF_EN
    ,
    .out_ovf_o   (out_ovf_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one tag, return its magnitude the next cycle, check the registered result.
  task automatic run_op(input string tag, input logic [3:0] sew, input logic [7:0] neg,
                        input logic [63:0] data, input logic [63:0] exp);
    iss_valid_i = 1'b1;
    iss_sew_i   = sew;
    iss_neg_i   = neg;
    @(posedge clk); #1;
    iss_valid_i = 1'b0;
    res_valid_i = 1'b1;
    res_data_i  = data;
    #1 chk({tag, "_rdy"}, 64'(res_ready_o), 64'd1);
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    chk({tag, "_vld"}, 64'(out_valid_o), 64'd1);
    chk(tag, out_data_o, exp);
    chk({tag, "_sew"}, 64'(out_sew_o), 64'(sew));
  endtask

  logic [7:0]  fill_neg [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [63:0] fill_exp [4] = '{64'h01010101010101FF, 64'h010101010101FF01,
                                64'h0101010101FF0101, 64'h01010101FF010101};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iss_valid_i = 1'b0; iss_sew_i = '0; iss_neg_i = '0;
    res_valid_i = 1'b0; res_data_i = '0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_rdy", 64'(iss_ready_o), 64'd0);
    chk("rst_res_rdy", 64'(res_ready_o), 64'd0);
    rst = 1'b0;
    chk("rst_cnt",  64'(tag_count_o), 64'd0);
    chk("rst_vld",  64'(out_valid_o), 64'd0);
    chk("rst_data", out_data_o, 64'd0);
    chk("rst_sew",  64'(out_sew_o), 64'd0);
    #1 chk("idle_iss_rdy", 64'(iss_ready_o), 64'd1);

    run_op("neg8",   4'b1000, 8'b00000101, 64'h0101010101010101, 64'h0101010101FF01FF);
    run_op("neg16",  4'b0100, 8'b00000010, 64'h3, 64'h000000000000FFFD);
    run_op("neg64",  4'b0001, 8'h80, 64'h1, 64'hFFFFFFFFFFFFFFFF);
    run_op("neg64z", 4'b0001, 8'h80, 64'h0, 64'h0);
    run_op("neg32",  4'b0010, 8'h88, 64'h8000000000000005, 64'h80000000FFFFFFFB);
    run_op("neg16c", 4'b0100, 8'hAA, 64'h0000010000010000, 64'h0000FF00FFFF0000);
    run_op("pos8",   4'b1000, 8'h00, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
    @(posedge clk); #1;
    chk("drain_vld", 64'(out_valid_o), 64'd0);

    // Fill the tag FIFO with the output held, then drain in order.
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iss_valid_i = 1'b1; iss_sew_i = 4'b1000; iss_neg_i = fill_neg[i];
      @(posedge clk); #1;
    end
    iss_valid_i = 1'b0;
    #1;
    chk("fill_cnt", 64'(tag_count_o), 64'd4);
    chk("fill_iss_rdy", 64'(iss_ready_o), 64'd0);
    res_valid_i = 1'b1; res_data_i = 64'h0101010101010101;
    #1 chk("fill_res_rdy", 64'(res_ready_o), 64'd1);
    @(posedge clk); #1;
    chk("bp_vld", 64'(out_valid_o), 64'd1);
    chk("bp_data0", out_data_o, fill_exp[0]);
    chk("bp_cnt", 64'(tag_count_o), 64'd3);
    chk("bp_res_rdy", 64'(res_ready_o), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_hold", out_data_o, fill_exp[0]);
      chk("bp_hold_rdy", 64'(res_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    #1 chk("rel_res_rdy", 64'(res_ready_o), 64'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("order_vld", 64'(out_valid_o), 64'd1);
      chk("order_data", out_data_o, fill_exp[i]);
    end
    res_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("order_end_vld", 64'(out_valid_o), 64'd0);
    chk("order_end_cnt", 64'(tag_count_o), 64'd0);

    // Result with no tag queued must wait for a tag.
    res_valid_i = 1'b1; res_data_i = 64'h00000000000000F0;
    #1 chk("empty_rdy0", 64'(res_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("empty_vld", 64'(out_valid_o), 64'd0);
    iss_valid_i = 1'b1; iss_sew_i = 4'b1000; iss_neg_i = 8'h01;
    #1 chk("empty_push_rdy", 64'(res_ready_o), 64'd0);
    @(posedge clk); #1;
    iss_valid_i = 1'b0;
    chk("empty_after_push_rdy", 64'(res_ready_o), 64'd1);
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    chk("empty_data", out_data_o, 64'h0000000000000010);
    @(posedge clk); #1;

    // Reset with tags queued and an output beat held.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iss_valid_i = 1'b1; iss_sew_i = 4'b1000; iss_neg_i = 8'h00;
      @(posedge clk); #1;
    end
    iss_valid_i = 1'b0; res_valid_i = 1'b1; res_data_i = 64'h5;
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    chk("prerst_cnt", 64'(tag_count_o), 64'd2);
    chk("prerst_vld", 64'(out_valid_o), 64'd1);
    rst = 1'b1; iss_valid_i = 1'b1; res_valid_i = 1'b1;
    #1;
    chk("inrst_iss_rdy", 64'(iss_ready_o), 64'd0);
    chk("inrst_res_rdy", 64'(res_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; iss_valid_i = 1'b0; res_valid_i = 1'b0; out_ready_i = 1'b1;
    chk("midrst_cnt", 64'(tag_count_o), 64'd0);
    chk("midrst_vld", 64'(out_valid_o), 64'd0);
    chk("midrst_data", out_data_o, 64'd0);

`ifdef SIMD_SIGN_FIXUP_OVF_EN
    run_op("ovf_pos", 4'b1000, 8'h00, 64'h80, 64'h80);
    chk("ovf_pos_flag", 64'(out_ovf_o), 64'h01);
    run_op("ovf_neg", 4'b1000, 8'h01, 64'h80, 64'h80);
    chk("ovf_neg_flag", 64'(out_ovf_o), 64'h00);
    run_op("ovf_neg16", 4'b0100, 8'h02, 64'h8001, 64'h7FFF);
    chk("ovf_neg16_flag", 64'(out_ovf_o), 64'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
